// File: rtl/sorted_vector_serializer.sv
// -----------------------------------------------------------------------------
// sorted_vector_serializer
//
// Output-side companion of the bitonic sorter. Captures each sorted vector
// presented with a one-cycle valid_in pulse and streams it out one element per
// valid/ready handshake, index 0 (smallest) first. The sorter cannot be
// stalled, so two vector slots are kept: the active slot being streamed and a
// pending slot holding the next vector. A vector arriving while both slots
// are occupied is dropped and flagged on the sticky overflow output.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   valid_in   in   one-cycle pulse, sorted_in valid this cycle
//   sorted_in  in   DEPTH x WIDTH unpacked array, index 0 smallest
//   in_ready   out  pending slot free (advisory; the sorter ignores it)
//   out_valid  out  stream element valid
//   out_ready  in   sink accepts the element
//   out_data   out  current element, active[idx]
//   out_idx    out  index of the current element within its vector
//   out_last   out  current element is index DEPTH-1
//   overflow   out  sticky, a vector was dropped
//   frame_cnt  out  completed vectors, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module sorted_vector_serializer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [WIDTH-1:0]         sorted_in [DEPTH],
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH)-1:0] out_idx,
    output logic                     out_last,
    output logic                     overflow,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [WIDTH-1:0]   active_r  [DEPTH];
    logic [WIDTH-1:0]   pending_r [DEPTH];
    logic               pending_full_r;
    logic [IDX_W-1:0]   idx_r;
    logic               overflow_r;
    logic [CNT_W-1:0]   frame_cnt_r;

    logic               xfer_s;
    logic               last_xfer_s;
    logic               load_active_in_s;
    logic               load_active_pend_s;
    logic               load_pend_s;
    logic               pend_full_nxt_s;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic               frame_inc_s;
    logic               set_ovf_s;

    // Stream outputs are all derived from registered state; out_data is a
    // plain mux over the active slot so there is no extra latency stage.
    assign out_valid   = (state_r == STREAM);
    assign out_data    = active_r[idx_r];
    assign out_idx     = idx_r;
    assign out_last    = out_valid && (idx_r == LAST_IDX);
    assign in_ready    = !pending_full_r;
    assign overflow    = overflow_r;
    assign frame_cnt   = frame_cnt_r;

    assign xfer_s      = out_valid && out_ready;
    assign last_xfer_s = xfer_s && (idx_r == LAST_IDX);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and slot-control decode.
    always_comb begin
        next_state_s       = state_r;
        load_active_in_s   = 1'b0;
        load_active_pend_s = 1'b0;
        load_pend_s        = 1'b0;
        pend_full_nxt_s    = pending_full_r;
        idx_nxt_s          = idx_r;
        frame_inc_s        = 1'b0;
        set_ovf_s          = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid_in) begin
                    load_active_in_s = 1'b1;
                    idx_nxt_s        = {IDX_W{1'b0}};
                    next_state_s     = STREAM;
                end else begin
                    next_state_s     = IDLE;
                end
            end
            STREAM: begin
                if (last_xfer_s) begin
                    // Frame done. The pending slot frees this cycle, so a
                    // coincident valid_in always has a place to go.
                    frame_inc_s = 1'b1;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    if (pending_full_r) begin
                        load_active_pend_s = 1'b1;
                        if (valid_in) begin
                            load_pend_s     = 1'b1;
                            pend_full_nxt_s = 1'b1;
                        end else begin
                            pend_full_nxt_s = 1'b0;
                        end
                    end else if (valid_in) begin
                        load_active_in_s = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    if (xfer_s) begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end else begin
                        idx_nxt_s = idx_r;
                    end
                    if (valid_in) begin
                        if (!pending_full_r) begin
                            load_pend_s     = 1'b1;
                            pend_full_nxt_s = 1'b1;
                        end else begin
                            set_ovf_s = 1'b1;
                        end
                    end else begin
                        set_ovf_s = 1'b0;
                    end
                end
            end
            default: begin
                next_state_s    = IDLE;
                pend_full_nxt_s = 1'b0;
                idx_nxt_s       = {IDX_W{1'b0}};
            end
        endcase
    end

    // Slot storage, element index, frame counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                active_r[i]  <= {WIDTH{1'b0}};
                pending_r[i] <= {WIDTH{1'b0}};
            end
            pending_full_r <= 1'b0;
            idx_r          <= {IDX_W{1'b0}};
            overflow_r     <= 1'b0;
            frame_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_active_in_s) begin
                    active_r[i] <= sorted_in[i];
                end else if (load_active_pend_s) begin
                    active_r[i] <= pending_r[i];
                end else begin
                    active_r[i] <= active_r[i];
                end
                if (load_pend_s) begin
                    pending_r[i] <= sorted_in[i];
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
            pending_full_r <= pend_full_nxt_s;
            idx_r          <= idx_nxt_s;
            overflow_r     <= overflow_r | set_ovf_s;
            if (frame_inc_s) begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_sorted_vector_serializer.sv
module tb_sorted_vector_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] din [8];
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        overflow;
    logic [15:0] frame_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] v1 [8] = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd7, 32'd10, 32'd18, 32'd25};
    logic [31:0] v2 [8] = '{32'd0, 32'd4, 32'd4, 32'd9, 32'd11, 32'd12, 32'd30, 32'd31};
    logic [31:0] v3 [8] = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd104, 32'd105, 32'd106, 32'd107};
    logic [31:0] exp_s [24];

    sorted_vector_serializer #(.WIDTH(32), .DEPTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .sorted_in (din),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"},  64'(out_data),  64'd0);
        chk({tag, "_idx"},   64'(out_idx),   64'd0);
        chk({tag, "_last"},  64'(out_last),  64'd0);
        chk({tag, "_ovf"},   64'(overflow),  64'd0);
        chk({tag, "_fcnt"},  64'(frame_cnt), 64'd0);
        chk({tag, "_inrdy"}, 64'(in_ready),  64'd1);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        valid_in  = 1'b0;
        out_ready = 1'b0;
        #3;
        chk_reset_vals("rst");
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Stream one full frame with out_ready held high, checking every beat.
    task automatic stream_frame(input logic [31:0] v [8], input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_data"},  64'(out_data),  64'(v[k]));
            chk({tag, "_idx"},   64'(out_idx),   64'(k));
            chk({tag, "_last"},  64'(out_last),  64'(k == 7));
            tick();
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < 8; i++) din[i] = 32'd0;

        // 1: basic stream
        do_reset();
        din = v1; valid_in = 1'b1; out_ready = 1'b1;
        chk("t1_pre_valid", 64'(out_valid), 64'd0);
        tick();
        valid_in = 1'b0;
        stream_frame(v1, "t1");
        chk("t1_end_valid", 64'(out_valid), 64'd0);
        chk("t1_fcnt", 64'(frame_cnt), 64'd1);

        // 2: backpressure with out_ready pattern 1,0,0,1,0,0,...
        do_reset();
        din = v1; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            if (k == 8) break;
            out_ready = (c % 3 == 0);
            chk("t2_valid", 64'(out_valid), 64'd1);
            chk("t2_data",  64'(out_data),  64'(v1[k]));
            chk("t2_idx",   64'(out_idx),   64'(k));
            if (out_ready) k++;
            tick();
        end
        chk("t2_count", 64'(k), 64'd8);
        chk("t2_end_valid", 64'(out_valid), 64'd0);
        chk("t2_fcnt", 64'(frame_cnt), 64'd1);

        // 3: double buffer, second vector 3 cycles after the first
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_s[i]     = v1[i];
            exp_s[i + 8] = v2[i];
        end
        din = v1; valid_in = 1'b1; out_ready = 1'b1;
        tick();
        for (int t = 0; t < 16; t++) begin
            valid_in = (t == 2);
            din = v2;
            chk("t3_valid", 64'(out_valid), 64'd1);
            chk("t3_data",  64'(out_data),  64'(exp_s[t]));
            chk("t3_idx",   64'(out_idx),   64'(t % 8));
            chk("t3_inrdy", 64'(in_ready),  64'(!(t >= 3 && t <= 7)));
            tick();
        end
        valid_in = 1'b0;
        chk("t3_end_valid", 64'(out_valid), 64'd0);
        chk("t3_fcnt", 64'(frame_cnt), 64'd2);
        chk("t3_ovf", 64'(overflow), 64'd0);

        // 4: overflow with the sink stalled
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            valid_in = (c % 2 == 0);
            din = (c == 0) ? v1 : ((c == 2) ? v2 : v3);
            if (c == 4) chk("t4_ovf_before", 64'(overflow), 64'd0);
            tick();
        end
        valid_in = 1'b0;
        chk("t4_ovf_set", 64'(overflow), 64'd1);
        chk("t4_inrdy", 64'(in_ready), 64'd0);
        chk("t4_hold_data", 64'(out_data), 64'd1);
        chk("t4_hold_idx", 64'(out_idx), 64'd0);
        stream_frame(v1, "t4a");
        stream_frame(v2, "t4b");
        chk("t4_end_valid", 64'(out_valid), 64'd0);
        chk("t4_ovf_sticky", 64'(overflow), 64'd1);
        chk("t4_fcnt", 64'(frame_cnt), 64'd2);

        // 5: valid_in coincides with the last-element transfer, both slots full
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_s[i]      = v1[i];
            exp_s[i + 8]  = v2[i];
            exp_s[i + 16] = v3[i];
        end
        din = v1; valid_in = 1'b1; out_ready = 1'b1;
        tick();
        for (int t = 0; t < 24; t++) begin
            valid_in = (t == 0) || (t == 7);
            din = (t == 0) ? v2 : v3;
            if (t == 7) chk("t5_inrdy_full", 64'(in_ready), 64'd0);
            chk("t5_valid", 64'(out_valid), 64'd1);
            chk("t5_data",  64'(out_data),  64'(exp_s[t]));
            chk("t5_idx",   64'(out_idx),   64'(t % 8));
            chk("t5_last",  64'(out_last),  64'(t % 8 == 7));
            chk("t5_ovf",   64'(overflow),  64'd0);
            tick();
        end
        valid_in = 1'b0;
        chk("t5_end_valid", 64'(out_valid), 64'd0);
        chk("t5_fcnt", 64'(frame_cnt), 64'd3);

        // 6: asynchronous reset at idx 3, frame counter starts from 3 here
        din = v1; valid_in = 1'b1; out_ready = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int t = 0; t < 3; t++) tick();
        chk("t6_idx3", 64'(out_idx), 64'd3);
        chk("t6_fcnt_pre", 64'(frame_cnt), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_reset_vals("t6_release");
        din = v2; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        stream_frame(v2, "t6");
        chk("t6_end_valid", 64'(out_valid), 64'd0);
        chk("t6_fcnt", 64'(frame_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
